// File: rtl/decode_regfile.sv
// Y86 decode stage: 8x32 register file, operand read, valid/ready output register.
// Optional DECODE_WB_BYPASS_EN forwards same-cycle writeback data to the operand reads.
module decode_regfile (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [31:0] valC,
    input  logic [31:0] valP,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_icode,
    output logic [3:0]  out_ifun,
    output logic [31:0] out_valA,
    output logic [31:0] out_valB,
    output logic [31:0] out_valC,
    output logic [3:0]  out_dstE,
    output logic [3:0]  out_dstM,
    input  logic [3:0]  wb_dstE,
    input  logic [3:0]  wb_dstM,
    input  logic [31:0] wb_valE,
    input  logic [31:0] wb_valM
);
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RESP  = 4'h4;

    logic [31:0] rf_q [8];
    logic [31:0] rf_d [8];

    logic [3:0]  src_a, src_b, dst_e, dst_m;
    logic        use_valp;
    logic [31:0] rd_a, rd_b, dec_val_a;
    logic        accept;

    logic        valid_q, valid_d;
    logic [3:0]  icode_q, icode_d, ifun_q, ifun_d;
    logic [31:0] val_a_q, val_a_d, val_b_q, val_b_d, val_c_q, val_c_d;
    logic [3:0]  dst_e_q, dst_e_d, dst_m_q, dst_m_d;

    always_comb begin
        src_a    = RNONE;
        src_b    = RNONE;
        dst_e    = RNONE;
        dst_m    = RNONE;
        use_valp = 1'b0;
        case (icode)
            4'h2: begin src_a = rA; dst_e = rB; end
            4'h3: begin dst_e = rB; end
            4'h4: begin src_a = rA; src_b = rB; end
            4'h5: begin src_b = rB; dst_m = rA; end
            4'h6: begin src_a = rA; src_b = rB; dst_e = rB; end
            4'h7: begin use_valp = 1'b1; end
            4'h8: begin use_valp = 1'b1; src_b = RESP; dst_e = RESP; end
            4'h9: begin src_a = RESP; src_b = RESP; dst_e = RESP; end
            4'hA: begin src_a = rA; src_b = RESP; dst_e = RESP; end
            4'hB: begin src_a = RESP; src_b = RESP; dst_e = RESP; dst_m = rA; end
            default: ;
        endcase
    end

    // IDs 8-15 (including 0xF "none") read as zero; M port checked last so it wins.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        if (!src_a[3]) rd_a = rf_q[src_a[2:0]];
        if (!src_b[3]) rd_b = rf_q[src_b[2:0]];
`ifdef DECODE_WB_BYPASS_EN
        if (!src_a[3] && wb_dstE == src_a) rd_a = wb_valE;
        if (!src_a[3] && wb_dstM == src_a) rd_a = wb_valM;
        if (!src_b[3] && wb_dstE == src_b) rd_b = wb_valE;
        if (!src_b[3] && wb_dstM == src_b) rd_b = wb_valM;
`endif
        dec_val_a = use_valp ? valP : rd_a;
    end

    always_comb begin
        rf_d = rf_q;
        if (!wb_dstE[3]) rf_d[wb_dstE[2:0]] = wb_valE;
        if (!wb_dstM[3]) rf_d[wb_dstM[2:0]] = wb_valM;
    end

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        icode_d = icode_q;
        ifun_d  = ifun_q;
        val_a_d = val_a_q;
        val_b_d = val_b_q;
        val_c_d = val_c_q;
        dst_e_d = dst_e_q;
        dst_m_d = dst_m_q;
        if (accept) begin
            valid_d = 1'b1;
            icode_d = icode;
            ifun_d  = ifun;
            val_a_d = dec_val_a;
            val_b_d = rd_b;
            val_c_d = valC;
            dst_e_d = dst_e;
            dst_m_d = dst_m;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rf_q    <= '{default: '0};
            valid_q <= 1'b0;
            icode_q <= '0;
            ifun_q  <= '0;
            val_a_q <= '0;
            val_b_q <= '0;
            val_c_q <= '0;
            dst_e_q <= RNONE;
            dst_m_q <= RNONE;
        end else begin
            rf_q    <= rf_d;
            valid_q <= valid_d;
            icode_q <= icode_d;
            ifun_q  <= ifun_d;
            val_a_q <= val_a_d;
            val_b_q <= val_b_d;
            val_c_q <= val_c_d;
            dst_e_q <= dst_e_d;
            dst_m_q <= dst_m_d;
        end
    end

    assign out_valid = valid_q;
    assign out_icode = icode_q;
    assign out_ifun  = ifun_q;
    assign out_valA  = val_a_q;
    assign out_valB  = val_b_q;
    assign out_valC  = val_c_q;
    assign out_dstE  = dst_e_q;
    assign out_dstM  = dst_m_q;
endmodule
